// File: rtl/cve2_wb_stage_pkg.sv
// Shared types and defaults for the writeback stage and its interface.
package cve2_wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultRfAddrW   = 5;

endpackage

// File: rtl/cve2_wb_stage_if.sv
// Bundle of ID/LSU-side inputs and RF/hazard/perf outputs of the writeback stage.
// The master side is ID/EX plus the LSU; the slave side is the writeback stage.
interface cve2_wb_stage_if import cve2_wb_stage_pkg::*; #(
  parameter int unsigned DataWidth = DefaultDataWidth,
  parameter int unsigned RfAddrW   = DefaultRfAddrW
) ();

  logic                 en_wb;
  wb_instr_type_e       instr_type_wb;
  logic                 instr_is_compressed_id;
  logic                 instr_perf_count_id;
  logic [RfAddrW-1:0]   rf_waddr_id;
  logic [DataWidth-1:0] rf_wdata_id;
  logic                 rf_we_id;
  logic [DataWidth-1:0] rf_wdata_lsu;
  logic                 rf_we_lsu;
  logic                 lsu_resp_valid;
  logic                 lsu_resp_err;

  logic                 ready_wb;
  logic                 rf_write_wb;
  logic [DataWidth-1:0] rf_wdata_fwd_wb;
  logic                 outstanding_load_wb;
  logic                 outstanding_store_wb;
  logic [RfAddrW-1:0]   rf_waddr_wb;
  logic [DataWidth-1:0] rf_wdata_wb;
  logic                 rf_we_wb;
  logic                 perf_instr_ret_wb;
  logic                 perf_instr_ret_compressed_wb;

  modport master (
    output en_wb, instr_type_wb, instr_is_compressed_id, instr_perf_count_id,
           rf_waddr_id, rf_wdata_id, rf_we_id, rf_wdata_lsu, rf_we_lsu,
           lsu_resp_valid, lsu_resp_err,
    input  ready_wb, rf_write_wb, rf_wdata_fwd_wb, outstanding_load_wb,
           outstanding_store_wb, rf_waddr_wb, rf_wdata_wb, rf_we_wb,
           perf_instr_ret_wb, perf_instr_ret_compressed_wb
  );

  modport slave (
    input  en_wb, instr_type_wb, instr_is_compressed_id, instr_perf_count_id,
           rf_waddr_id, rf_wdata_id, rf_we_id, rf_wdata_lsu, rf_we_lsu,
           lsu_resp_valid, lsu_resp_err,
    output ready_wb, rf_write_wb, rf_wdata_fwd_wb, outstanding_load_wb,
           outstanding_store_wb, rf_waddr_wb, rf_wdata_wb, rf_we_wb,
           perf_instr_ret_wb, perf_instr_ret_compressed_wb
  );

endinterface

// File: rtl/cve2_wb_stage.sv
// Writeback stage: either a one-entry register that holds the retiring instruction
// and merges late load data into it, or a combinational bypass for small configs.
module cve2_wb_stage import cve2_wb_stage_pkg::*; #(
  parameter bit          WritebackStage = 1'b1,
  parameter int unsigned DataWidth      = DefaultDataWidth,
  parameter int unsigned RfAddrW        = DefaultRfAddrW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  cve2_wb_stage_if.slave  wb
);

  logic [RfAddrW-1:0]   rf_waddr_sel;
  logic [DataWidth-1:0] rf_wdata_id_sel;
  logic                 rf_we_id_sel;
  logic                 rf_we_lsu_sel;
  logic                 perf_ret_sel;
  logic                 perf_ret_comp_sel;
  logic                 ready_sel;
  logic                 rf_write_sel;
  logic [DataWidth-1:0] rf_wdata_fwd_sel;
  logic                 outstanding_load_sel;
  logic                 outstanding_store_sel;

  if (WritebackStage) begin : g_writeback_stage
    logic                 wb_valid_q;
    logic [RfAddrW-1:0]   waddr_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 we_q;
    wb_instr_type_e       type_q;
    logic                 compressed_q;
    logic                 perf_q;
    logic                 wb_done;
    logic                 ready;
    logic                 resp_err;

    assign wb_done  = wb_valid_q & ((type_q == WB_INSTR_OTHER) | wb.lsu_resp_valid);
    assign ready    = ~wb_valid_q | wb_done;
    assign resp_err = wb.lsu_resp_valid & wb.lsu_resp_err;

    // Occupancy flag: fills on handoff from ID, drains once the held instruction completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wb_valid_q <= 1'b0;
      end else if (wb.en_wb & ready) begin
        wb_valid_q <= 1'b1;
      end else if (wb_done) begin
        wb_valid_q <= 1'b0;
      end
    end

    // Payload of the held instruction, replaced whenever a new one is accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        waddr_q      <= '0;
        wdata_q      <= '0;
        we_q         <= 1'b0;
        type_q       <= WB_INSTR_LOAD;
        compressed_q <= 1'b0;
        perf_q       <= 1'b0;
      end else if (wb.en_wb & ready) begin
        waddr_q      <= wb.rf_waddr_id;
        wdata_q      <= wb.rf_wdata_id;
        we_q         <= wb.rf_we_id;
        type_q       <= wb.instr_type_wb;
        compressed_q <= wb.instr_is_compressed_id;
        perf_q       <= wb.instr_perf_count_id;
      end
    end

    assign rf_waddr_sel          = waddr_q;
    assign rf_wdata_id_sel       = wdata_q;
    assign rf_we_id_sel          = wb_valid_q & we_q;
    assign perf_ret_sel          = wb_done & perf_q & ~resp_err;
    assign perf_ret_comp_sel     = perf_ret_sel & compressed_q;
    assign ready_sel             = ready;
    assign rf_write_sel          = wb_valid_q & (we_q | (type_q == WB_INSTR_LOAD));
    assign rf_wdata_fwd_sel      = wdata_q;
    assign outstanding_load_sel  = wb_valid_q & (type_q == WB_INSTR_LOAD);
    assign outstanding_store_sel = wb_valid_q & (type_q == WB_INSTR_STORE);

    // ID may only hand over an instruction when the stage can take it
    a_no_handoff_when_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(wb.en_wb & ~ready));

    // An LSU response must belong to the load or store currently held here
    a_resp_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      wb.lsu_resp_valid |-> (outstanding_load_sel | outstanding_store_sel));

    c_wb_valid: cover property (@(posedge clk_i) disable iff (!rst_ni) wb_valid_q);
  end else begin : g_bypass_wb
    assign rf_waddr_sel          = wb.rf_waddr_id;
    assign rf_wdata_id_sel       = wb.rf_wdata_id;
    assign rf_we_id_sel          = wb.rf_we_id;
    assign perf_ret_sel          = wb.instr_perf_count_id & ~(wb.lsu_resp_valid & wb.lsu_resp_err);
    assign perf_ret_comp_sel     = perf_ret_sel & wb.instr_is_compressed_id;
    assign ready_sel             = 1'b1;
    assign rf_write_sel          = 1'b0;
    assign rf_wdata_fwd_sel      = '0;
    assign outstanding_load_sel  = 1'b0;
    assign outstanding_store_sel = 1'b0;
  end

  assign rf_we_lsu_sel = wb.rf_we_lsu & ~wb.lsu_resp_err;

  assign wb.rf_waddr_wb                  = rf_waddr_sel;
  assign wb.rf_we_wb                     = rf_we_id_sel | rf_we_lsu_sel;
  assign wb.rf_wdata_wb                  = ({DataWidth{rf_we_id_sel}}  & rf_wdata_id_sel) |
                                           ({DataWidth{rf_we_lsu_sel}} & wb.rf_wdata_lsu);
  assign wb.ready_wb                     = ready_sel;
  assign wb.rf_write_wb                  = rf_write_sel;
  assign wb.rf_wdata_fwd_wb              = rf_wdata_fwd_sel;
  assign wb.outstanding_load_wb          = outstanding_load_sel;
  assign wb.outstanding_store_wb         = outstanding_store_sel;
  assign wb.perf_instr_ret_wb            = perf_ret_sel;
  assign wb.perf_instr_ret_compressed_wb = perf_ret_comp_sel;

  // The ID result and the load data share one RF write port
  a_single_rf_source: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rf_we_id_sel & rf_we_lsu_sel));

endmodule

// File: tb/tb_cve2_wb_stage.sv
// Bench for cve2_wb_stage: directed scenarios plus random traffic on the registered
// instance, and directed/random traffic on a bypass instance.
module tb_cve2_wb_stage;
  import cve2_wb_stage_pkg::*;

  typedef struct {
    logic        en;
    logic [1:0]  kind;
    logic        comp;
    logic        perf;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we_id;
    logic [31:0] lsu_data;
    logic        we_lsu;
    logic        resp;
    logic        err;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [1:0]  kind;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        comp;
    logic        perf;
  } held_t;

  logic  clk;
  logic  rst_n;
  int    vectors;
  int    miscompares;
  stim_t cur;
  held_t held;

  cve2_wb_stage_if ifr ();
  cve2_wb_stage_if ifb ();

  cve2_wb_stage #(.WritebackStage(1'b1)) dut_reg (.clk_i(clk), .rst_ni(rst_n), .wb(ifr));
  cve2_wb_stage #(.WritebackStage(1'b0)) dut_byp (.clk_i(clk), .rst_ni(rst_n), .wb(ifb));

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.en = 1'b0; s.kind = WB_INSTR_OTHER; s.comp = 1'b0; s.perf = 1'b0;
    s.waddr = '0; s.wdata = '0; s.we_id = 1'b0; s.lsu_data = '0;
    s.we_lsu = 1'b0; s.resp = 1'b0; s.err = 1'b0;
    return s;
  endfunction

  function automatic stim_t alu(input logic [4:0] waddr, input logic [31:0] wdata, input logic comp);
    stim_t s = idle();
    s.en = 1'b1; s.kind = WB_INSTR_OTHER; s.waddr = waddr; s.wdata = wdata;
    s.we_id = 1'b1; s.perf = 1'b1; s.comp = comp;
    return s;
  endfunction

  function automatic stim_t load(input logic [4:0] waddr);
    stim_t s = idle();
    s.en = 1'b1; s.kind = WB_INSTR_LOAD; s.waddr = waddr; s.perf = 1'b1;
    return s;
  endfunction

  function automatic stim_t lsuResp(input logic [31:0] data, input logic we, input logic err);
    stim_t s = idle();
    s.resp = 1'b1; s.lsu_data = data; s.we_lsu = we; s.err = err;
    return s;
  endfunction

  function automatic logic heldDone();
    return held.valid && (held.kind == WB_INSTR_OTHER || cur.resp);
  endfunction

  // Drive the registered instance and settle to mid-cycle
  task automatic applyStimulus(input stim_t s);
    cur = s;
    ifr.en_wb                  = s.en;
    ifr.instr_type_wb          = wb_instr_type_e'(s.kind);
    ifr.instr_is_compressed_id = s.comp;
    ifr.instr_perf_count_id    = s.perf;
    ifr.rf_waddr_id            = s.waddr;
    ifr.rf_wdata_id            = s.wdata;
    ifr.rf_we_id               = s.we_id;
    ifr.rf_wdata_lsu           = s.lsu_data;
    ifr.rf_we_lsu              = s.we_lsu;
    ifr.lsu_resp_valid         = s.resp;
    ifr.lsu_resp_err           = s.err;
    #4;
  endtask

  task automatic applyBypass(input stim_t s);
    ifb.en_wb                  = s.en;
    ifb.instr_type_wb          = wb_instr_type_e'(s.kind);
    ifb.instr_is_compressed_id = s.comp;
    ifb.instr_perf_count_id    = s.perf;
    ifb.rf_waddr_id            = s.waddr;
    ifb.rf_wdata_id            = s.wdata;
    ifb.rf_we_id               = s.we_id;
    ifb.rf_wdata_lsu           = s.lsu_data;
    ifb.rf_we_lsu              = s.we_lsu;
    ifb.lsu_resp_valid         = s.resp;
    ifb.lsu_resp_err           = s.err;
    #4;
  endtask

  // Expected registered-stage outputs from the held instruction and this cycle's inputs
  task automatic modelCheck();
    logic done, ready, from_id, from_lsu, retire;
    done     = heldDone();
    ready    = !held.valid || done;
    from_id  = held.valid && held.we;
    from_lsu = cur.we_lsu && !cur.err;
    retire   = done && held.perf && !(cur.resp && cur.err);
    checkOutput("ready", 32'(ifr.ready_wb), 32'(ready));
    checkOutput("rf_we", 32'(ifr.rf_we_wb), 32'(from_id || from_lsu));
    if (from_id || from_lsu) begin
      checkOutput("rf_waddr", 32'(ifr.rf_waddr_wb), 32'(held.waddr));
      checkOutput("rf_wdata", ifr.rf_wdata_wb, from_id ? held.wdata : cur.lsu_data);
    end
    checkOutput("rf_write", 32'(ifr.rf_write_wb),
                32'(held.valid && (held.we || held.kind == WB_INSTR_LOAD)));
    if (held.valid) checkOutput("fwd", ifr.rf_wdata_fwd_wb, held.wdata);
    checkOutput("out_load", 32'(ifr.outstanding_load_wb), 32'(held.valid && held.kind == WB_INSTR_LOAD));
    checkOutput("out_store", 32'(ifr.outstanding_store_wb), 32'(held.valid && held.kind == WB_INSTR_STORE));
    checkOutput("ret", 32'(ifr.perf_instr_ret_wb), 32'(retire));
    checkOutput("ret_c", 32'(ifr.perf_instr_ret_compressed_wb), 32'(retire && held.comp));
  endtask

  // Move the model to the next cycle and step past the clock edge
  task automatic advance();
    logic done, ready;
    done  = heldDone();
    ready = !held.valid || done;
    if (cur.en && ready) begin
      held.valid = 1'b1; held.kind = cur.kind; held.waddr = cur.waddr;
      held.wdata = cur.wdata; held.we = cur.we_id; held.comp = cur.comp; held.perf = cur.perf;
    end else if (done) begin
      held.valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic clearModel();
    held.valid = 1'b0; held.kind = WB_INSTR_LOAD; held.waddr = '0;
    held.wdata = '0; held.we = 1'b0; held.comp = 1'b0; held.perf = 1'b0;
  endtask

  function automatic stim_t randStim();
    stim_t s = idle();
    logic  done;
    if (held.valid && held.kind != WB_INSTR_OTHER && $urandom_range(0, 2) == 0) begin
      s.resp = 1'b1; s.err = ($urandom_range(0, 3) == 0);
      s.we_lsu = (held.kind == WB_INSTR_LOAD); s.lsu_data = $urandom;
    end
    done = held.valid && (held.kind == WB_INSTR_OTHER || s.resp);
    if ((!held.valid || done) && $urandom_range(0, 2) != 0) begin
      s.en = 1'b1; s.kind = 2'($urandom_range(0, 2));
      s.waddr = 5'($urandom); s.wdata = $urandom;
      s.we_id = (s.kind == WB_INSTR_OTHER) ? 1'($urandom_range(0, 1)) : 1'b0;
      s.comp = 1'($urandom_range(0, 1)); s.perf = 1'($urandom_range(0, 1));
    end
    return s;
  endfunction

  initial begin
    int n_we, n_ret, n_retc, n_notready;
    stim_t s;
    vectors = 0; miscompares = 0;
    clearModel();
    rst_n = 1'b0;
    applyStimulus(idle());
    applyBypass(idle());
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(ifr.ready_wb), 32'd1);
    checkOutput("reset_rf_we", 32'(ifr.rf_we_wb), 32'd0);
    checkOutput("reset_rf_write", 32'(ifr.rf_write_wb), 32'd0);
    checkOutput("reset_out_load", 32'(ifr.outstanding_load_wb), 32'd0);
    checkOutput("reset_ret", 32'(ifr.perf_instr_ret_wb), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU op: written and retired the cycle after handoff, single pulse
    applyStimulus(alu(5'd5, 32'hDEADBEEF, 1'b0)); modelCheck(); advance();
    applyStimulus(idle()); modelCheck();
    checkOutput("alu_we", 32'(ifr.rf_we_wb), 32'd1);
    checkOutput("alu_waddr", 32'(ifr.rf_waddr_wb), 32'd5);
    checkOutput("alu_wdata", ifr.rf_wdata_wb, 32'hDEADBEEF);
    checkOutput("alu_ret", 32'(ifr.perf_instr_ret_wb), 32'd1);
    advance();
    applyStimulus(idle()); modelCheck();
    checkOutput("alu_ret_once", 32'(ifr.perf_instr_ret_wb), 32'd0);
    advance();

    // Load with a three-cycle wait before its response
    applyStimulus(load(5'd7)); modelCheck(); advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(idle()); modelCheck();
      checkOutput("load_wait_ready", 32'(ifr.ready_wb), 32'd0);
      advance();
    end
    applyStimulus(lsuResp(32'h1234, 1'b1, 1'b0)); modelCheck();
    checkOutput("load_we", 32'(ifr.rf_we_wb), 32'd1);
    checkOutput("load_waddr", 32'(ifr.rf_waddr_wb), 32'd7);
    checkOutput("load_wdata", ifr.rf_wdata_wb, 32'h1234);
    checkOutput("load_ret", 32'(ifr.perf_instr_ret_wb), 32'd1);
    advance();

    // Errored load: frees the stage without writing or retiring
    applyStimulus(load(5'd9)); modelCheck(); advance();
    applyStimulus(lsuResp(32'hCAFE, 1'b1, 1'b1)); modelCheck();
    checkOutput("err_we", 32'(ifr.rf_we_wb), 32'd0);
    checkOutput("err_ret", 32'(ifr.perf_instr_ret_wb), 32'd0);
    checkOutput("err_ready", 32'(ifr.ready_wb), 32'd1);
    advance();
    applyStimulus(idle()); modelCheck();
    checkOutput("err_freed", 32'(ifr.outstanding_load_wb), 32'd0);
    advance();

    // Back-to-back compressed ALU ops
    n_we = 0; n_ret = 0; n_retc = 0; n_notready = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i < 8) ? alu(5'(i + 1), $urandom, 1'b1) : idle());
      modelCheck();
      n_we       += int'(ifr.rf_we_wb);
      n_ret      += int'(ifr.perf_instr_ret_wb);
      n_retc     += int'(ifr.perf_instr_ret_compressed_wb);
      n_notready += int'(!ifr.ready_wb);
      advance();
    end
    checkOutput("b2b_writes", n_we, 8);
    checkOutput("b2b_ret", n_ret, 8);
    checkOutput("b2b_ret_c", n_retc, 8);
    checkOutput("b2b_stall", n_notready, 0);

    // Reset while a load is outstanding
    applyStimulus(load(5'd3)); modelCheck(); advance();
    applyStimulus(idle());
    checkOutput("rst_pre_out", 32'(ifr.outstanding_load_wb), 32'd1);
    rst_n = 1'b0; #1;
    checkOutput("rst_out_load", 32'(ifr.outstanding_load_wb), 32'd0);
    checkOutput("rst_rf_write", 32'(ifr.rf_write_wb), 32'd0);
    checkOutput("rst_ready", 32'(ifr.ready_wb), 32'd1);
    checkOutput("rst_ret", 32'(ifr.perf_instr_ret_wb), 32'd0);
    clearModel();
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(idle()); modelCheck();
      checkOutput("post_rst_we", 32'(ifr.rf_we_wb), 32'd0);
      checkOutput("post_rst_ret", 32'(ifr.perf_instr_ret_wb), 32'd0);
      advance();
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(randStim()); modelCheck(); advance();
    end
    applyStimulus(idle());

    // Bypass instance: ALU op writes and retires in the handoff cycle
    applyBypass(alu(5'd5, 32'hDEADBEEF, 1'b0));
    checkOutput("byp_we", 32'(ifb.rf_we_wb), 32'd1);
    checkOutput("byp_waddr", 32'(ifb.rf_waddr_wb), 32'd5);
    checkOutput("byp_wdata", ifb.rf_wdata_wb, 32'hDEADBEEF);
    checkOutput("byp_ret", 32'(ifb.perf_instr_ret_wb), 32'd1);
    checkOutput("byp_ready", 32'(ifb.ready_wb), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      s = idle();
      s.en = 1'b1; s.waddr = 5'($urandom); s.comp = 1'($urandom_range(0, 1));
      s.perf = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        s.we_id = 1'b1; s.wdata = $urandom;
      end else begin
        s.kind = WB_INSTR_LOAD; s.resp = 1'b1; s.we_lsu = 1'b1;
        s.err = ($urandom_range(0, 2) == 0); s.lsu_data = $urandom;
      end
      applyBypass(s);
      checkOutput("byp_r_we", 32'(ifb.rf_we_wb), 32'(s.we_id || (s.we_lsu && !s.err)));
      if (s.we_id) checkOutput("byp_r_wdata", ifb.rf_wdata_wb, s.wdata);
      else if (!s.err) checkOutput("byp_r_wdata", ifb.rf_wdata_wb, s.lsu_data);
      checkOutput("byp_r_ret", 32'(ifb.perf_instr_ret_wb), 32'(s.perf && !(s.resp && s.err)));
      checkOutput("byp_r_ret_c", 32'(ifb.perf_instr_ret_compressed_wb),
                  32'(s.perf && s.comp && !(s.resp && s.err)));
      checkOutput("byp_r_rf_write", 32'(ifb.rf_write_wb), 32'd0);
      checkOutput("byp_r_out", 32'(ifb.outstanding_load_wb | ifb.outstanding_store_wb), 32'd0);
      @(posedge clk); #1;
    end
    applyBypass(idle());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
